// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign/zero/upper/branch) feeding a 2-entry FIFO; result, tag and mode are stored at accept time.
// Latency: 1 cycle from accept to out_valid. Backpressure: registered in_ready drops while both entries are full.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
  } entry_t;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  entry_t           wr_entry;
  entry_t           rd_entry;

  always_comb begin
    sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext  = sext;
    case (mode_e'(in_mode))
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = {{EXT_W{1'b0}}, in_imm};
      MODE_UPPER:  ext = {in_imm, {EXT_W{1'b0}}};
      // IN_W <= OUT_W-2 guarantees the two dropped MSBs are sign copies.
      MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:     ext = sext;
    endcase
  end

  assign wr_entry.imm  = ext;
  assign wr_entry.tag  = in_tag;
  assign wr_entry.mode = in_mode;

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       rdy_q;
  logic       wr_en;
  logic       rd_en;

  assign wr_en = in_valid && rdy_q;
  assign rd_en = out_ready && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!wr_en && rd_en) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
      // Registered so in_ready never depends combinationally on out_ready.
      rdy_q <= (cnt_d != 2'd2);
    end
  end

  assign rd_entry  = mem_q[rd_ptr_q];
  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_imm   = rd_entry.imm;
  assign out_tag   = rd_entry.tag;
  assign out_mode  = rd_entry.mode;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic [1:0]  out_mode;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [11:0] n_in_imm;
  logic [1:0]  n_in_mode;
  logic [4:0]  n_in_tag;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [31:0] n_out_imm;
  logic [4:0]  n_out_tag;
  logic [1:0]  n_out_mode;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic [1:0]  mode;
  } item_t;

  item_t q[$];
  bit    model_rdy;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_mode(out_mode)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_imm(n_in_imm), .in_mode(n_in_mode), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_imm(n_out_imm), .out_tag(n_out_tag),
    .out_mode(n_out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic view of the extension rules for a 16-bit immediate into 32 bits.
  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] mode);
    longint u;
    longint s;
    longint r;
    u = longint'(imm);
    s = (u >= 32768) ? u - 65536 : u;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = s * 4;
    endcase
    r = r & 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  // Advance one clock; the model applies the transfers implied by the current inputs.
  task automatic step();
    bit    push;
    bit    pop;
    item_t it;
    push = in_valid && model_rdy;
    pop  = out_ready && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      it.imm  = ext_ref(in_imm, in_mode);
      it.tag  = in_tag;
      it.mode = in_mode;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    model_rdy = (q.size() < 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 0;
    n_in_valid = 0; n_in_imm = '0; n_in_mode = '0; n_in_tag = '0; n_out_ready = 0;
    model_rdy = 0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    checks++;
    if (out_imm !== 32'h0 || out_tag !== 5'h0 || out_mode !== 2'h0) begin
      errors++;
      $display("FAIL reset_data imm=%h tag=%h mode=%h required 0 0 0", out_imm, out_tag, out_mode);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_modes();
    logic [15:0] imms [5];
    logic [1:0]  modes [5];
    logic [31:0] exps [5];
    imms[0] = 16'h8004; modes[0] = 2'd0; exps[0] = 32'hFFFF8004;
    imms[1] = 16'hFFFE; modes[1] = 2'd1; exps[1] = 32'h0000FFFE;
    imms[2] = 16'hFFFE; modes[2] = 2'd2; exps[2] = 32'hFFFE0000;
    imms[3] = 16'hFFFE; modes[3] = 2'd3; exps[3] = 32'hFFFFFFF8;
    imms[4] = 16'h7FFF; modes[4] = 2'd3; exps[4] = 32'h0001FFFC;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 5'(i + 3);
      step();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== exps[i] || out_tag !== 5'(i + 3) || out_mode !== modes[i]) begin
        errors++;
        $display("FAIL mode_vec%0d valid=%b imm=%h tag=%0d mode=%0d required 1 %h %0d %0d",
                 i, out_valid, out_imm, out_tag, out_mode, exps[i], i + 3, modes[i]);
      end
      out_ready = 1;
      step();
      out_ready = 0;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_imm = 16'h1111; in_mode = 2'd1; in_tag = 5'd1;
    step();
    in_imm = 16'h2222; in_tag = 5'd2;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full in_ready=%b required 0", in_ready);
    end
    in_imm = 16'h3333; in_tag = 5'd3;
    step();
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h00001111 || out_tag !== 5'd1) begin
      errors++;
      $display("FAIL bp_hold valid=%b imm=%h tag=%0d required 1 00001111 1", out_valid, out_imm, out_tag);
    end
    out_ready = 1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_imm !== 32'h00002222 || out_tag !== 5'd2) begin
      errors++;
      $display("FAIL bp_second in_ready=%b imm=%h tag=%0d required 1 00002222 2", in_ready, out_imm, out_tag);
    end
    step();
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dropped_third out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_imm = 16'h0100; in_mode = 2'd0; in_tag = 5'd0;
    step();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'(i + 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || q.size() != 1 ||
          out_imm !== q[0].imm || out_tag !== q[0].tag) begin
        errors++;
        $display("FAIL b2b_item%0d valid=%b rdy=%b imm=%h tag=%0d required 1 1 %h %0d",
                 i, out_valid, in_ready, out_imm, out_tag, q[0].imm, q[0].tag);
      end
    end
    in_valid = 0;
    step();
    out_ready = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== model_rdy) begin
        errors++;
        $display("FAIL rand_flags cyc%0d valid=%b rdy=%b required %b %b",
                 i, out_valid, in_ready, q.size() != 0, model_rdy);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_imm !== q[0].imm || out_tag !== q[0].tag || out_mode !== q[0].mode) begin
          errors++;
          $display("FAIL rand_head cyc%0d imm=%h tag=%0d mode=%0d required %h %0d %0d",
                   i, out_imm, out_tag, out_mode, q[0].imm, q[0].tag, q[0].mode);
        end
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) step();
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_imm = 16'hABCD; in_mode = 2'd0; in_tag = 5'd7;
    step();
    in_tag = 5'd8;
    step();
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async valid=%b rdy=%b required 0 0", out_valid, in_ready);
    end
    q.delete();
    model_rdy = 0;
    #1;
    rst_n = 1'b1;
    out_ready = 1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release rdy=%b valid=%b required 1 0", in_ready, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_old valid=%b required 0", out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_narrow();
    n_in_valid = 1; n_in_imm = 12'h800; n_in_mode = 2'd0; n_in_tag = 5'd9;
    step();
    n_in_valid = 0;
    checks++;
    if (n_out_valid !== 1'b1 || n_out_imm !== 32'hFFFFF800 || n_out_tag !== 5'd9) begin
      errors++;
      $display("FAIL narrow_sign valid=%b imm=%h tag=%0d required 1 FFFFF800 9", n_out_valid, n_out_imm, n_out_tag);
    end
    n_out_ready = 1;
    n_in_valid = 1; n_in_mode = 2'd2; n_in_tag = 5'd10;
    step();
    n_in_valid = 0;
    checks++;
    if (n_out_valid !== 1'b1 || n_out_imm !== 32'h80000000 || n_out_tag !== 5'd10) begin
      errors++;
      $display("FAIL narrow_upper valid=%b imm=%h tag=%0d required 1 80000000 10", n_out_valid, n_out_imm, n_out_tag);
    end
    step();
    n_out_ready = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 1..OUT_W-2.
REQ-002 Parameter OUT_W, default 32, extended output width.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried with each item (e.g. destination register).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer presents an item.
REQ-007 in_ready  output  1  block can accept an item this cycle.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
REQ-010 in_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-011 out_valid  output  1  head item available.
REQ-012 out_ready  input  1  consumer takes head item.
REQ-013 out_imm  output  OUT_W  extended result of the head item (signed interpretation for modes 00/11).
REQ-014 out_tag  output  TAG_W  tag of the head item.
REQ-015 out_mode  output  2  mode of the head item.

Function
REQ-016 An input transfer occurs when in_valid && in_ready at a clock edge; an output transfer when out_valid && out_ready.
REQ-017 The extension result SHALL be computed combinationally from in_imm/in_mode and stored at accept time; stored items do not change.
REQ-018 Mode 00: result = in_imm[IN_W-1] replicated OUT_W-IN_W times, concatenated with in_imm (total exactly OUT_W bits).
REQ-019 Mode 01: result = OUT_W-IN_W zeros concatenated with in_imm.
REQ-020 Mode 10: result = in_imm in bits [OUT_W-1:OUT_W-IN_W], zeros below.
REQ-021 Mode 11: result = (mode-00 result) shifted left 2, zeros in bits [1:0]; the two discarded MSBs are sign copies, so no information is lost given REQ-001.
REQ-022 Storage is a 2-entry FIFO (entries hold result, tag, mode); count 0..2, write and read pointers 1 bit each, wrapping 1->0.
REQ-023 Latency: an item accepted at edge N appears on out_* with out_valid=1 after edge N, when the FIFO was empty before N.
REQ-024 out_valid = (count != 0); out_imm/out_tag/out_mode = head entry; when count=0 outputs hold last head values (don't-care, not checked).
REQ-025 in_ready SHALL be a registered signal equal to (count < 2) after each edge; it does not depend combinationally on out_ready.
REQ-026 Simultaneous input and output transfer at count 1: count stays 1, head advances, new item becomes head next cycle.
REQ-027 Simultaneous transfers at count 2 cannot occur (in_ready=0); an output transfer at count 2 sets count 1 and in_ready 1 after the edge.
REQ-028 Output transfer at count 0 is impossible; input at count 2 is ignored (no overwrite, no pointer change).
REQ-029 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 Items exit in strict acceptance order; none are duplicated or dropped.

Reset
REQ-031 While rst_n=0 (asserted asynchronously, any cycle): count=0, pointers=0, out_valid=0, in_ready=0, out_imm=0, out_tag=0, out_mode=0.
REQ-032 First edge after rst_n deasserts sets in_ready=1; no transfer occurs on that edge.
REQ-033 Reset mid-operation discards all stored items; no item accepted before reset appears after it.

Verification
REQ-034 Defaults, mode 00, in_imm=16'h8004, tag 3 -> one cycle later out_valid=1, out_imm=32'hFFFF8004, out_tag=3.
REQ-035 Modes 01/10/11 with in_imm=16'hFFFE -> 32'h0000FFFE, 32'hFFFE0000, 32'hFFFFFFF8; with 16'h7FFF mode 11 -> 32'h0001FFFC.
REQ-036 out_ready=0, push A,B -> in_ready=0 after second accept, third in_valid ignored; release out_ready -> A then B, in_ready=1 one cycle after A leaves.
REQ-037 count 1, in_valid and out_ready both high every cycle for 10 items -> count stays 1, out order matches input, throughput 1 item/cycle.
REQ-038 Two items held, rst_n pulsed low mid-cycle -> out_valid=0 immediately, after release in_ready=1, no old item emitted.
REQ-039 IN_W=12, OUT_W=32, mode 00, in_imm=12'h800 -> 32'hFFFFF800; mode 10 -> 32'h80000000.
